traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_CYCLES, default 5, expected red dwell in clock cycles.
REQ-002 Parameter GREEN_CYCLES, default 5, expected green dwell in clock cycles.
REQ-003 Parameter YELLOW_CYCLES, default 2, expected yellow dwell in clock cycles.
REQ-004 Port clk  input  1  single clock; all state on posedge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port red / yellow / green  input  1 each  light outputs of the controller under observation.
REQ-007 Port phase  output  2  current tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW.
REQ-008 Port synced  output  1  high while the monitor holds a timed phase lock.
REQ-009 Port err_onehot  output  1  one-cycle pulse: the lights were not exactly one-hot.
REQ-010 Port err_order  output  1  one-cycle pulse: the light transition was not R->G, G->Y or Y->R.
REQ-011 Port err_timing  output  1  one-cycle pulse: the dwell did not equal the expected cycles.
REQ-012 Port err_sticky  output  1  OR of all error pulses since reset.
REQ-013 Port cycle_count  output  8  number of completed legal, timed R->G->Y->R cycles, wraps 255->0.

Function
REQ-014 Inputs SHALL be sampled on every posedge clk; all outputs SHALL be registered; an error pulse SHALL be asserted in the cycle after the edge that samples the offending value.
REQ-015 FSM states SHALL be SYNC, RED, GREEN, YELLOW; phase SHALL equal the state encoding.
REQ-016 Dwell counter SHALL be 8 bits wide, SHALL reset to 1 on each phase entry, SHALL increment on each same-light sample, and SHALL saturate at 255.
REQ-017 SYNC: the first one-hot sample SHALL enter the matching state with its timed flag cleared, and the first dwell after SYNC SHALL NOT be timing-checked.
REQ-018 A legal transition (R->G, G->Y, Y->R) SHALL move to the new state; if the timed flag is set and the dwell is not equal to the expected cycles of the old phase, err_timing SHALL pulse, and the timed flag SHALL then be set.
REQ-019 An illegal transition SHALL pulse err_order, move to the observed light's state, and clear the timed flag; the next dwell SHALL NOT be timing-checked.
REQ-020 While in a phase with the timed flag set, err_timing SHALL pulse once when dwell reaches expected+1, and SHALL NOT pulse again at that phase's exit.
REQ-021 Non-one-hot sample (zero or more than one light high): err_onehot SHALL pulse and the FSM SHALL go to SYNC with the timed flag cleared; consecutive bad samples SHALL pulse err_onehot every cycle.
REQ-022 synced SHALL be high iff the state is not SYNC and the timed flag is set.
REQ-023 cycle_count SHALL increment on a Y->R transition only when the R, G and Y dwells of that cycle were all timed and error-free.
REQ-024 Simultaneous timing and order faults on one sample: only err_order SHALL pulse.

Reset
REQ-025 On rst: phase=0 (SYNC), synced=0, all err_* outputs=0, err_sticky=0, cycle_count=0, dwell=0, timed flag=0.
REQ-026 Reset asserted mid-phase SHALL abort immediately, and the first sample after release SHALL be treated per REQ-017.

Structure
REQ-027 Package traffic_light_pkg SHALL hold the phase encoding constants and the default RED/GREEN/YELLOW cycle counts, shared with the traffic_light controller.
REQ-028 One sub-module tl_dwell_counter (load-to-1, increment, saturate, compare-to-expected) SHALL be used; FSM and error logic SHALL stay in the top.

Verification
REQ-029 Reset then legal sequence R5 G5 Y2 repeated 3 times -> first cycle untimed; synced=1 from first R->G; cycle_count=2; no errors.
REQ-030 Green held 7 cycles after sync -> err_timing pulses once when dwell=6; err_sticky=1; no pulse at G->Y.
REQ-031 Yellow held 1 cycle after sync -> err_timing pulses at Y->R; cycle_count unchanged.
REQ-032 R->Y directly -> err_order pulse; phase=3; synced=0; err_timing never pulses for that yellow dwell.
REQ-033 Red and green both high for 2 cycles -> err_onehot pulses twice; phase=0; resync on next clean red.
REQ-034 rst asserted mid-green -> all outputs at reset values asynchronously; cycle_count=0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase encoding and default dwell lengths shared by the traffic light controller and monitor.
package traffic_light_pkg;
    typedef enum logic [1:0] {SYNC = 2'd0, RED = 2'd1, GREEN = 2'd2, YELLOW = 2'd3} phase_t;
    localparam int DEF_RED_CYCLES = 5;
    localparam int DEF_GREEN_CYCLES = 5;
    localparam int DEF_YELLOW_CYCLES = 2;
    function automatic phase_t light_phase(input logic red, input logic green, input logic yellow);
        return red ? RED : green ? GREEN : yellow ? YELLOW : SYNC;
    endfunction
    function automatic phase_t next_phase(input phase_t p);
        return p == RED ? GREEN : p == GREEN ? YELLOW : p == YELLOW ? RED : SYNC;
    endfunction
endpackage

// File: rtl/tl_dwell_counter.sv
// tl_dwell_counter: saturating count of samples spent in the current phase, compared against the expected dwell.
module tl_dwell_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       inc,
    input  logic [7:0] expected,
    output logic [7:0] dwell,
    output logic       at_exp
);
    always_ff @(posedge clk or posedge rst)
        if (rst) dwell <= 8'd0;
        else if (load) dwell <= 8'd1;
        else if (inc && dwell != 8'hff) dwell <= dwell + 8'd1;
    assign at_exp = dwell == expected;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: tracks an observed R->G->Y light sequence, flags one-hot, order and dwell faults,
// and counts fully timed error-free cycles.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic [1:0] phase,
    output logic       synced,
    output logic       err_onehot,
    output logic       err_order,
    output logic       err_timing,
    output logic       err_sticky,
    output logic [7:0] cycle_count
);
    phase_t state, state_d, seen;
    logic timed, timed_d, cycle_ok, cycle_ok_d;
    logic onehot, same, legal, at_exp;
    logic onehot_d, order_d, timing_d, count_d;
    logic [7:0] dwell, expected;

    assign onehot = $onehot({red, green, yellow});
    assign seen = light_phase(red, green, yellow);
    assign same = state == seen;
    assign legal = seen == next_phase(state);
    assign expected = state == RED ? 8'(RED_CYCLES) : state == GREEN ? 8'(GREEN_CYCLES) : 8'(YELLOW_CYCLES);

    tl_dwell_counter u_dwell (
        .clk(clk), .rst(rst), .load(onehot && !same), .inc(onehot && same),
        .expected(expected), .dwell(dwell), .at_exp(at_exp)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= SYNC;
            timed <= 1'b0;
            cycle_ok <= 1'b0;
        end else begin
            state <= state_d;
            timed <= timed_d;
            cycle_ok <= cycle_ok_d;
        end

    always_comb begin
        state_d = state;
        timed_d = timed;
        if (!onehot) begin
            state_d = SYNC;
            timed_d = 1'b0;
        end else if (!same) begin
            state_d = seen;
            timed_d = legal;
        end
    end

    // Overstay is flagged on reaching expected+1, so a late exit only checks for an early one.
    always_comb begin
        onehot_d = !onehot;
        order_d = onehot && !same && state != SYNC && !legal;
        timing_d = onehot && timed && (same ? at_exp : legal && dwell < expected);
        count_d = onehot && !same && legal && state == YELLOW && timed && at_exp && cycle_ok;
        cycle_ok_d = onehot && !same && legal ? (state == YELLOW || (cycle_ok && timed && at_exp)) : cycle_ok;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            err_onehot <= 1'b0;
            err_order <= 1'b0;
            err_timing <= 1'b0;
            err_sticky <= 1'b0;
            cycle_count <= 8'd0;
        end else begin
            err_onehot <= onehot_d;
            err_order <= order_d;
            err_timing <= timing_d;
            err_sticky <= err_sticky || onehot_d || order_d || timing_d;
            if (count_d) cycle_count <= cycle_count + 8'd1;
        end

    assign phase = state;
    assign synced = timed && state != SYNC;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed light sequences with hand-computed monitor responses.
module tb_traffic_light_monitor;
    logic clk = 1'b0, rst = 1'b1, red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic [1:0] phase;
    logic synced, err_onehot, err_order, err_timing, err_sticky;
    logic [7:0] cycle_count;
    int checks = 0, failures = 0, n_t = 0, n_o = 0, n_h = 0;
    localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001, RG = 3'b110, NONE = 3'b000;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .phase(phase), .synced(synced), .err_onehot(err_onehot), .err_order(err_order),
        .err_timing(err_timing), .err_sticky(err_sticky), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] l);
        {red, green, yellow} = l;
        @(posedge clk);
        #1;
        n_t += int'(err_timing);
        n_o += int'(err_order);
        n_h += int'(err_onehot);
    endtask

    task automatic run(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) tick(l);
    endtask

    task automatic clear_counts();
        n_t = 0;
        n_o = 0;
        n_h = 0;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_phase", phase, 0);
        check("rst_synced", synced, 0);
        check("rst_errs", {err_onehot, err_order, err_timing, err_sticky}, 0);
        check("rst_count", cycle_count, 0);
        rst = 1'b0;
        // three legal cycles, first one untimed, closed by a red sample
        tick(R);
        check("sync_r_phase", phase, 1);
        check("sync_r_synced", synced, 0);
        run(R, 4);
        tick(G);
        check("first_rg_synced", synced, 1);
        check("first_rg_phase", phase, 2);
        run(G, 4); run(Y, 2);
        for (int c = 0; c < 2; c++) begin
            run(R, 5); run(G, 5); run(Y, 2);
        end
        tick(R);
        check("legal_count", cycle_count, 2);
        check("legal_pulses", n_t + n_o + n_h, 0);
        check("legal_sticky", err_sticky, 0);
        // green overstays to 7
        run(R, 4); run(G, 5);
        check("g5_no_timing", err_timing, 0);
        tick(G);
        check("g6_timing", err_timing, 1);
        check("g6_sticky", err_sticky, 1);
        tick(G);
        check("g7_timing", err_timing, 0);
        tick(Y);
        check("gy_no_timing", err_timing, 0);
        tick(Y); tick(R);
        check("long_g_count", cycle_count, 2);
        // yellow too short
        run(R, 4); run(G, 5); tick(Y); tick(R);
        check("short_y_timing", err_timing, 1);
        check("short_y_count", cycle_count, 2);
        // recovery cycle is counted again
        clear_counts();
        run(R, 4); run(G, 5); run(Y, 2); tick(R);
        check("recover_count", cycle_count, 3);
        check("recover_pulses", n_t + n_o + n_h, 0);
        // red (short) straight to yellow: order only, untimed yellow
        clear_counts();
        tick(R); tick(Y);
        check("ry_order", err_order, 1);
        check("ry_no_timing", err_timing, 0);
        check("ry_phase", phase, 3);
        check("ry_synced", synced, 0);
        run(Y, 4); tick(R);
        check("ry_timing_total", n_t, 0);
        check("ry_order_total", n_o, 1);
        check("yr_synced", synced, 1);
        // two-lights-on then all-off
        clear_counts();
        tick(RG);
        check("rg1_onehot", err_onehot, 1);
        check("rg1_phase", phase, 0);
        tick(RG);
        check("rg2_onehot", err_onehot, 1);
        tick(NONE);
        check("none_onehot", err_onehot, 1);
        tick(R);
        check("resync_onehot", err_onehot, 0);
        check("resync_phase", phase, 1);
        check("resync_synced", synced, 0);
        check("onehot_total", n_h, 3);
        // async reset mid-green
        run(R, 4); run(G, 2);
        check("pre_rst_phase", phase, 2);
        #2 rst = 1'b1;
        #1;
        check("arst_phase", phase, 0);
        check("arst_synced", synced, 0);
        check("arst_sticky", err_sticky, 0);
        check("arst_count", cycle_count, 0);
        #1 rst = 1'b0;
        clear_counts();
        tick(G);
        check("post_rst_phase", phase, 2);
        check("post_rst_synced", synced, 0);
        run(G, 2); tick(Y);
        check("post_rst_untimed", n_t, 0);
        check("post_rst_gy_synced", synced, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
